// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry and loader phase encodings.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BYTE_W      = 8;

  typedef enum logic [1:0] {
    PH_LOAD_KEY = 2'd0,
    PH_LOAD_PT  = 2'd1,
    PH_PRESENT  = 2'd2
  } phase_t;

endpackage

// File: rtl/aes_byte_shreg.sv
// 128-bit shift register taking one byte per enabled cycle; the newest byte lands in the
// low byte, so the first byte of a block ends up in [127:120].
module aes_byte_shreg
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic [AES_BYTE_W-1:0]  i_byte,
  output logic [AES_BLOCK_W-1:0] o_q
);

  logic [AES_BLOCK_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_q <= '0;
    else if (i_en)
      r_q <= {r_q[AES_BLOCK_W-AES_BYTE_W-1:0], i_byte};
  end

  assign o_q = r_q;

endmodule

// File: rtl/aes_block_loader.sv
// Assembles an AES-128 key and plaintext from a byte stream and presents them as
// committed registers, so the downstream core never sees a partially loaded block.
module aes_block_loader
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         key_hold,
  output logic [127:0] out_key,
  output logic [127:0] out_plain_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   phase,
  output logic [3:0]   byte_cnt
);

  localparam logic [3:0] LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);

  phase_t                 r_state;
  phase_t                 w_next;
  logic [3:0]             r_byte_cnt;
  logic [AES_BLOCK_W-1:0] r_out_key;
  logic [AES_BLOCK_W-1:0] r_out_pt;
  logic                   r_out_valid;
  logic [AES_BLOCK_W-1:0] w_key_q;
  logic [AES_BLOCK_W-1:0] w_pt_q;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_hs;
  logic                   w_unused_pt_msb;

  assign in_ready = (r_state != PH_PRESENT);
  assign w_accept = in_valid && in_ready;
  assign w_last   = w_accept && (r_byte_cnt == LAST_BYTE);
  assign w_hs     = r_out_valid && out_ready;

  aes_byte_shreg u_key_sreg (
    .clk    (clk),
    .i_clr  (rst),
    .i_en   (w_accept && (r_state == PH_LOAD_KEY)),
    .i_byte (in_data),
    .o_q    (w_key_q)
  );

  aes_byte_shreg u_pt_sreg (
    .clk    (clk),
    .i_clr  (rst),
    .i_en   (w_accept && (r_state == PH_LOAD_PT)),
    .i_byte (in_data),
    .o_q    (w_pt_q)
  );

  // The commit folds the final byte in directly, so the top plaintext byte is shifted out.
  assign w_unused_pt_msb = ^w_pt_q[AES_BLOCK_W-1 -: AES_BYTE_W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= PH_LOAD_KEY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      PH_LOAD_KEY: if (w_last) w_next = PH_LOAD_PT;
      PH_LOAD_PT:  if (w_last) w_next = PH_PRESENT;
      PH_PRESENT:  if (w_hs)   w_next = key_hold ? PH_LOAD_PT : PH_LOAD_KEY;
      default:                 w_next = PH_LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_out_key   <= '0;
      r_out_pt    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept)
        r_byte_cnt <= w_last ? 4'd0 : r_byte_cnt + 4'd1;
      // With key_hold the key register was not reloaded, so the old key is recommitted.
      if ((r_state == PH_LOAD_PT) && w_last) begin
        r_out_key   <= w_key_q;
        r_out_pt    <= {w_pt_q[AES_BLOCK_W-AES_BYTE_W-1:0], in_data};
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_key        = r_out_key;
  assign out_plain_text = r_out_pt;
  assign out_valid      = r_out_valid;
  assign phase          = r_state;
  assign byte_cnt       = r_byte_cnt;

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: driver pushes expected blocks, monitor checks
// every cycle against a phase/count model and pops expectations when out_valid rises.
module tb_aes_block_loader;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PB = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         key_hold;
  logic [127:0] out_key;
  logic [127:0] out_plain_text;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   phase;
  logic [3:0]   byte_cnt;

  int           total = 0;
  int           bad   = 0;
  blk_t         exp_q[$];
  logic [127:0] cur_key = '0;

  always #5 clk = ~clk;

  aes_block_loader dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .key_hold       (key_hold),
    .out_key        (out_key),
    .out_plain_text (out_plain_text),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .phase          (phase),
    .byte_cnt       (byte_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int rgap();
    int g = 0;
    while (g < 8 && $urandom_range(0, 99) >= 30) g++;
    return g;
  endfunction

  // Drive at negedge; the byte is accepted at the following posedge once in_ready is seen.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                            input bit hold, input bit gaps);
    exp_q.push_back('{key: (hold ? cur_key : k), pt: p});
    if (!hold) begin
      for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], gaps ? rgap() : 0);
      cur_key = k;
    end
    for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8], gaps ? rgap() : 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic handshake(input logic kh);
    out_ready = 1'b1;
    key_hold  = kh;
    @(negedge clk);
    out_ready = 1'b0;
    key_hold  = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each posedge; inputs are stable there since the
  // driver only changes them at negedge, and p_* hold the pre-edge DUT outputs.
  initial begin
    logic         armed = 1'b0, p_valid = 1'b0, p_ready = 1'b0, acc, hs;
    logic [1:0]   m_ph = 2'd0;
    logic [3:0]   m_cnt = 4'd0;
    logic [127:0] c_key = '0, c_pt = '0;
    blk_t         e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        armed = 1'b1;
        m_ph  = 2'd0;
        m_cnt = 4'd0;
        c_key = '0;
        c_pt  = '0;
      end else if (armed) begin
        acc = in_valid && p_ready;
        hs  = p_valid && out_ready;
        if (hs) begin
          chk("valid_drop_after_hs", out_valid, 0);
          m_ph = key_hold ? 2'd1 : 2'd0;
        end else if (p_valid) begin
          chk("valid_held", out_valid, 1);
        end
        if (acc) begin
          if (m_cnt == 4'd15) begin
            m_cnt = 4'd0;
            m_ph  = m_ph + 2'd1;
          end else begin
            m_cnt = m_cnt + 4'd1;
          end
        end
        if (!p_valid && out_valid) begin
          chk("latency_final_accept", acc, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_block", 1, 0);
          end else begin
            e = exp_q.pop_front();
            c_key = e.key;
            c_pt  = e.pt;
          end
        end
        chk("out_key", out_key, c_key);
        chk("out_plain_text", out_plain_text, c_pt);
        chk("byte_cnt", byte_cnt, m_cnt);
        chk("phase", phase, m_ph);
        chk("in_ready", in_ready, m_ph != 2'd2);
      end
      p_valid = out_valid;
      p_ready = in_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; key_hold = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_phase", phase, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_key", out_key, 0);
    chk("rst_out_pt", out_plain_text, 0);

    // FIPS-197 vector, back to back, then backpressure with live input traffic
    send_block(K1, P1, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i * 7 + 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    handshake(1'b1);
    chk("hs_valid_low", out_valid, 0);
    chk("hold_phase_pt", phase, 1);

    // key held: plaintext-only load
    send_block(K1, PB, 1'b1, 1'b0);
    wait_valid();
    chk("hold_key_kept", out_key, K1);
    handshake(1'b0);

    // FIPS vector with random input gaps
    send_block(K1, P1, 1'b0, 1'b1);
    wait_valid();
    handshake(1'b0);

    // Reset after 20 bytes discards the partial block
    for (int i = 0; i < 16; i++) send_byte(K1[127-8*i -: 8], 0);
    for (int i = 0; i < 4; i++) send_byte(P1[127-8*i -: 8], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_byte_cnt", byte_cnt, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_key", out_key, 0);
    chk("mid_rst_out_pt", out_plain_text, 0);

    // Fresh load with out_ready held high throughout
    out_ready = 1'b1;
    send_block(K1, P1, 1'b0, 1'b0);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    chk("final_out_valid", out_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
